// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory controller.
//   dmem_state_t     - controller FSM state encoding (IDLE, WAIT, RESP)
//   DMEM_DEPTH_DEF   - default storage depth in 32-bit words
//   DMEM_LATENCY_DEF - default request-to-valid latency in cycles
//   WE_WRITE/WE_READ - encodings of the we_re request qualifier
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam int DMEM_DEPTH_DEF   = 1024;
  localparam int DMEM_LATENCY_DEF = 2;

  localparam logic WE_WRITE = 1'b1;
  localparam logic WE_READ  = 1'b0;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x DATA_WIDTH word storage with per-byte write enables and
// a registered (synchronous) read port. Contents have no reset.
// Ports:
//   clk   - rising-edge clock
//   we    - write strobe, qualified per byte by be
//   re    - read strobe; rdata updates only when re is high
//   be    - byte enables, bit i covers wdata[8i+7:8i]
//   idx   - word index shared by the read and write port
//   wdata - write data
//   rdata - read data register, holds its value between reads
module dmem_array #(
  parameter int DEPTH      = 1024,
  parameter int IDX_W      = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [3:0]            be,
  input  logic [IDX_W-1:0]      idx,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_r;

  // Byte-masked write and registered read of the storage array.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem_r[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
    if (re) begin
      rdata_r <= mem_r[idx];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: single-outstanding data-memory controller with fixed latency.
// A request is accepted in IDLE, optionally held in WAIT, and completed with a
// one-cycle valid pulse in RESP. Writes commit on the edge entering RESP.
// Optional feature macro: DMEM_ERR_CHECK_EN (out-of-range address detection;
// without it addresses wrap modulo DEPTH*4).
// Ports:
//   clk        - rising-edge clock
//   rst        - asynchronous reset, active low
//   request    - core request, held until valid
//   we_re      - 1 = write, 0 = read
//   mask       - byte enables for writes
//   address    - byte address, bits [1:0] ignored
//   store_data - write data
//   load_data  - read data, held until the next read response
//   valid      - one-cycle completion pulse
//   addr_err   - out-of-range flag, qualified by valid
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDRESS    = 32,
  parameter int DEPTH      = DMEM_DEPTH_DEF,
  parameter int LATENCY    = DMEM_LATENCY_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  request,
  input  logic                  we_re,
  input  logic [3:0]            mask,
  input  logic [ADDRESS-1:0]    address,
  input  logic [DATA_WIDTH-1:0] store_data,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  valid,
  output logic                  addr_err
);

  localparam int IDX_W = $clog2(DEPTH);

  dmem_state_t           state_r;
  logic [3:0]            cnt_r;
  logic [ADDRESS-1:0]    addr_r;
  logic                  we_r;
  logic [3:0]            mask_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  valid_r;
  logic                  addr_err_r;
  logic                  ld_clr_r;

  logic [ADDRESS-1:0]    cur_addr_s;
  logic                  cur_we_s;
  logic [3:0]            cur_mask_s;
  logic [DATA_WIDTH-1:0] cur_data_s;
  logic                  enter_resp_s;
  logic                  commit_s;
  logic                  oor_s;
  logic [DATA_WIDTH-1:0] rdata_s;
  logic                  unused_bits_s;

  // Transaction view on the edge that enters RESP: live inputs when entering
  // straight from IDLE (LATENCY=1), captured registers otherwise.
  always_comb begin
    cur_addr_s   = addr_r;
    cur_we_s     = we_r;
    cur_mask_s   = mask_r;
    cur_data_s   = data_r;
    enter_resp_s = 1'b0;
    case (state_r)
      IDLE: begin
        cur_addr_s   = address;
        cur_we_s     = we_re;
        cur_mask_s   = mask;
        cur_data_s   = store_data;
        enter_resp_s = request && (LATENCY == 1);
      end
      WAIT:    enter_resp_s = (cnt_r == 4'd0);
      RESP:    enter_resp_s = 1'b0;
      default: enter_resp_s = 1'b0;
    endcase
  end

`ifdef DMEM_ERR_CHECK_EN
  assign oor_s         = (cur_addr_s >> (IDX_W + 2)) != {ADDRESS{1'b0}};
  assign unused_bits_s = ^cur_addr_s[1:0];
`else
  assign oor_s         = 1'b0;
  assign unused_bits_s = ^{cur_addr_s[ADDRESS-1:IDX_W+2], cur_addr_s[1:0]};
`endif

  // Gate with rst so nothing reaches the array while reset is held.
  assign commit_s = enter_resp_s & rst & ~oor_s;

  // FSM, latency counter, capture registers and response flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      cnt_r      <= 4'd0;
      addr_r     <= {ADDRESS{1'b0}};
      we_r       <= 1'b0;
      mask_r     <= 4'b0000;
      data_r     <= {DATA_WIDTH{1'b0}};
      valid_r    <= 1'b0;
      addr_err_r <= 1'b0;
      ld_clr_r   <= 1'b1;
    end else begin
      valid_r    <= enter_resp_s;
      addr_err_r <= enter_resp_s & oor_s;
      // A read response either exposes the fresh array word or forces zero.
      if (enter_resp_s && (cur_we_s == WE_READ)) begin
        ld_clr_r <= oor_s;
      end
      case (state_r)
        IDLE: begin
          if (request) begin
            addr_r <= address;
            we_r   <= we_re;
            mask_r <= mask;
            data_r <= store_data;
            if (LATENCY == 1) begin
              state_r <= RESP;
            end else begin
              state_r <= WAIT;
              cnt_r   <= 4'(LATENCY - 2);
            end
          end
        end
        WAIT: begin
          if (cnt_r == 4'd0) begin
            state_r <= RESP;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        RESP:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  dmem_array #(
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clk   (clk),
    .we    (commit_s & (cur_we_s == WE_WRITE)),
    .re    (commit_s & (cur_we_s == WE_READ)),
    .be    (cur_mask_s),
    .idx   (cur_addr_s[IDX_W+1:2]),
    .wdata (cur_data_s),
    .rdata (rdata_s)
  );

  // The array output has no reset; ld_clr_r masks it after reset and after
  // an out-of-range read, and it only changes on read responses.
  assign load_data = ld_clr_r ? {DATA_WIDTH{1'b0}} : rdata_s;
  assign valid     = valid_r;
  assign addr_err  = addr_err_r;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: one instance at LATENCY=2, one at
// LATENCY=1, sharing the request payload but with separate request lines.
module tb_data_mem_ctrl;
  import dmem_pkg::*;

  logic        clk;
  logic        rst;
  logic        req2;
  logic        req1;
  logic        we_re;
  logic [3:0]  mask;
  logic [31:0] address;
  logic [31:0] store_data;
  logic [31:0] ld2, ld1;
  logic        valid2, valid1;
  logic        err2, err1;

  int errors;
  int checks;

  logic [31:0] rd;
  logic        er;

  data_mem_ctrl #(.DATA_WIDTH(32), .ADDRESS(32), .DEPTH(1024), .LATENCY(2)) u_dut2 (
    .clk(clk), .rst(rst), .request(req2), .we_re(we_re), .mask(mask),
    .address(address), .store_data(store_data),
    .load_data(ld2), .valid(valid2), .addr_err(err2)
  );

  data_mem_ctrl #(.DATA_WIDTH(32), .ADDRESS(32), .DEPTH(1024), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .request(req1), .we_re(we_re), .mask(mask),
    .address(address), .store_data(store_data),
    .load_data(ld1), .valid(valid1), .addr_err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction on the selected instance (sel=1 -> LATENCY=1 instance).
  // rel_rst releases reset just before the accepting edge.
  task automatic txn(input logic sel, input logic rel_rst, input logic w,
                     input logic [3:0] m, input logic [31:0] a, input logic [31:0] d,
                     input int exp_lat, output logic [31:0] rdo, output logic ero);
    int   lat;
    logic seen;
    @(negedge clk);
    we_re = w; mask = m; address = a; store_data = d;
    if (sel) req1 = 1'b1; else req2 = 1'b1;
    if (rel_rst) begin
      #2 rst = 1'b1;
    end
    @(posedge clk);
    lat = 0; seen = 1'b0; rdo = 32'h0; ero = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (sel ? valid1 : valid2) begin
        seen = 1'b1;
        rdo  = sel ? ld1 : ld2;
        ero  = sel ? err1 : err2;
      end
    end
    req1 = 1'b0; req2 = 1'b0;
    check_val("latency", 32'(lat), 32'(exp_lat));
    @(negedge clk);
    check_val("valid_one_cycle", {31'h0, sel ? valid1 : valid2}, 32'h0);
  endtask

  initial begin
    errors = 0; checks = 0;
    rst = 1'b0; req2 = 1'b0; req1 = 1'b0; we_re = 1'b0; mask = 4'h0;
    address = 32'h0; store_data = 32'h0;
    #12;
    check_val("rst_valid", {31'h0, valid2}, 32'h0);
    check_val("rst_addr_err", {31'h0, err2}, 32'h0);
    check_val("rst_load_data", ld2, 32'h0);
    check_val("rst_valid_l1", {31'h0, valid1}, 32'h0);

    // Full-word write then read, first accept right after reset release.
    txn(1'b0, 1'b1, WE_WRITE, 4'b1111, 32'h10, 32'hDEADBEEF, 2, rd, er);
    check_val("wr_hold_load_data", ld2, 32'h0);
    txn(1'b0, 1'b0, WE_READ, 4'b0000, 32'h10, 32'h0, 2, rd, er);
    check_val("rd_full_word", rd, 32'hDEADBEEF);

    // Single-byte write merges into the existing word.
    txn(1'b0, 1'b0, WE_WRITE, 4'b0001, 32'h10, 32'h000000AA, 2, rd, er);
    check_val("load_held_over_write", ld2, 32'hDEADBEEF);
    txn(1'b0, 1'b0, WE_READ, 4'b1111, 32'h10, 32'h0, 2, rd, er);
    check_val("rd_byte_merge", rd, 32'hDEADBEAA);

    // Empty mask completes but writes nothing.
    txn(1'b0, 1'b0, WE_WRITE, 4'b0000, 32'h10, 32'h55555555, 2, rd, er);
    txn(1'b0, 1'b0, WE_READ, 4'b0000, 32'h10, 32'h0, 2, rd, er);
    check_val("rd_mask_zero", rd, 32'hDEADBEAA);

    // Reset during WAIT of a write abandons it.
    txn(1'b0, 1'b0, WE_WRITE, 4'b1111, 32'h20, 32'h11111111, 2, rd, er);
    @(negedge clk);
    we_re = WE_WRITE; mask = 4'b1111; address = 32'h20; store_data = 32'h22222222;
    req2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("midrst_valid", {31'h0, valid2}, 32'h0);
    check_val("midrst_state", 32'(u_dut2.state_r), 32'(IDLE));
    check_val("midrst_load_data", ld2, 32'h0);
    req2 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    txn(1'b0, 1'b0, WE_READ, 4'b1111, 32'h20, 32'h0, 2, rd, er);
    check_val("rd_after_abandon", rd, 32'h11111111);

    // Request held high; address wiggles during WAIT and is put back in RESP.
    @(negedge clk);
    we_re = WE_READ; mask = 4'b1111; address = 32'h10; req2 = 1'b1;
    begin
      int nvalid;
      nvalid = 0;
      for (int i = 1; i <= 9; i++) begin
        @(negedge clk);
        check_val("held_valid_pattern", {31'h0, valid2}, {31'h0, (i % 3) == 2});
        if (valid2) begin
          nvalid++;
          check_val("held_captured_data", ld2, 32'hDEADBEAA);
        end
        if ((i % 3) == 1) address = 32'h20;
        else if ((i % 3) == 2) address = 32'h10;
      end
      req2 = 1'b0;
      check_val("held_valid_count", 32'(nvalid), 32'd3);
    end

    // Address at DEPTH*4: flagged and dropped, or wrapped onto word 0.
    txn(1'b0, 1'b0, WE_WRITE, 4'b1111, 32'h0, 32'hCAFEF00D, 2, rd, er);
    txn(1'b0, 1'b0, WE_READ, 4'b1111, 32'h1000, 32'h0, 2, rd, er);
`ifdef DMEM_ERR_CHECK_EN
    check_val("oor_rd_err", {31'h0, er}, 32'h1);
    check_val("oor_rd_data", rd, 32'h0);
`else
    check_val("wrap_rd_err", {31'h0, er}, 32'h0);
    check_val("wrap_rd_data", rd, 32'hCAFEF00D);
`endif
    txn(1'b0, 1'b0, WE_WRITE, 4'b1111, 32'h1000, 32'h12345678, 2, rd, er);
`ifdef DMEM_ERR_CHECK_EN
    check_val("oor_wr_err", {31'h0, er}, 32'h1);
`else
    check_val("wrap_wr_err", {31'h0, er}, 32'h0);
`endif
    txn(1'b0, 1'b0, WE_READ, 4'b1111, 32'h0, 32'h0, 2, rd, er);
    check_val("inrange_err", {31'h0, er}, 32'h0);
`ifdef DMEM_ERR_CHECK_EN
    check_val("oor_wr_dropped", rd, 32'hCAFEF00D);
`else
    check_val("wrap_wr_word0", rd, 32'h12345678);
`endif

    // LATENCY=1 instance: single-cycle latency and back-to-back spacing.
    txn(1'b1, 1'b0, WE_WRITE, 4'b1111, 32'h40, 32'h5A5A5A5A, 1, rd, er);
    txn(1'b1, 1'b0, WE_READ, 4'b0000, 32'h40, 32'h0, 1, rd, er);
    check_val("l1_rd_data", rd, 32'h5A5A5A5A);
    @(negedge clk);
    we_re = WE_READ; address = 32'h40; req1 = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check_val("l1_held_valid", {31'h0, valid1}, {31'h0, (i % 2) == 1});
    end
    req1 = 1'b0;
    check_val("l1_load_held", ld1, 32'h5A5A5A5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the data bus width in bits.
REQ-002 SHALL have parameter ADDRESS, default 32, meaning the address bus width in bits.
REQ-003 SHALL have parameter DEPTH, default 1024, meaning storage size in 32-bit words; power of two required.
REQ-004 SHALL have parameter LATENCY, default 2, meaning cycles from request acceptance to valid; legal range 1..15.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous reset, active-low.
REQ-007 SHALL have port request, input, 1 bit: core data-memory request.
REQ-008 SHALL have port we_re, input, 1 bit: 1 = write (store), 0 = read (load).
REQ-009 SHALL have port mask, input, 4 bits: byte enables, where bit i covers data[8i+7:8i].
REQ-010 SHALL have port address, input, ADDRESS bits: byte address, with bits [1:0] ignored.
REQ-011 SHALL have port store_data, input, DATA_WIDTH bits: write data.
REQ-012 SHALL have port load_data, output, DATA_WIDTH bits: registered read data.
REQ-013 SHALL have port valid, output, 1 bit: one-cycle completion pulse, feeding the core's DM_valid.
REQ-014 SHALL have port addr_err, output, 1 bit: out-of-range flag, qualified by valid (only with DMEM_ERR_CHECK_EN).

Function
REQ-015 SHALL implement an FSM with states IDLE, WAIT, RESP.
REQ-016 SHALL accept a request only in IDLE with request=1, capturing address, we_re, mask and store_data into registers.
REQ-017 SHALL go from IDLE to RESP when LATENCY=1; otherwise from IDLE to WAIT with a counter loaded to LATENCY-2.
REQ-018 SHALL stay in WAIT, decrementing the counter, and go to RESP when the counter is 0.
REQ-019 SHALL assert valid only in RESP, for exactly one cycle, then return to IDLE; a request accepted at edge t gives valid high in cycle t+LATENCY.
REQ-020 SHALL ignore request in WAIT and in RESP; the core holds request until it sees valid, and the next acceptance occurs in the following IDLE cycle.
REQ-021 SHALL commit a write on the edge that enters RESP, writing only the bytes whose mask bit is 1; a mask of 0000 writes nothing but still completes.
REQ-022 SHALL present read data on load_data during the RESP cycle as the full word at the captured index, with mask not applied on reads.
REQ-023 SHALL hold load_data through IDLE, WAIT and write responses until the next read response.
REQ-024 SHALL use word index address[log2(DEPTH)+1:2].
REQ-025 SHALL never let a changing address or store_data after acceptance affect the in-flight transaction.

Reset
REQ-026 SHALL, on rst=0 (asynchronous, any state including mid-transaction), set state=IDLE, counter=0, valid=0, load_data=0, addr_err=0 and all capture registers to 0.
REQ-027 SHALL leave storage contents unaffected by reset and abandon an in-flight write without committing it.
REQ-028 SHALL accept the first request on the first rising edge after rst deasserts.

Configuration
REQ-029 SHALL, with macro DMEM_ERR_CHECK_EN defined, set addr_err=1 with valid when the accepted address is at or above DEPTH*4; such a read returns load_data=0 and such a write is dropped.
REQ-030 SHALL, without DMEM_ERR_CHECK_EN, tie addr_err to 0 and wrap the address modulo DEPTH*4 using the index bits only.

Structure
REQ-031 SHALL place in package dmem_pkg: the FSM state enum (dmem_state_t), DMEM_DEPTH_DEF=1024, DMEM_LATENCY_DEF=2, and the WE_WRITE/WE_READ encodings.
REQ-032 SHALL instantiate one sub-module, dmem_array: DEPTH x 32 storage with per-byte write enables and synchronous read, without reset.
REQ-033 SHALL keep the FSM, counter, capture registers and error check in data_mem_ctrl.

Verification
REQ-034 SHALL cover: LATENCY=2, write 0xDEADBEEF to 0x10 with mask 1111, then read 0x10 -> valid two cycles after each acceptance and load_data=0xDEADBEEF.
REQ-035 SHALL cover: after REQ-034, write 0x000000AA with mask 0001, then read 0x10 -> load_data=0xDEADBEAA.
REQ-036 SHALL cover: request held high continuously, with address changed during WAIT -> exactly one valid per LATENCY+1 cycles, and data taken from the captured address.
REQ-037 SHALL cover: rst pulsed low in WAIT of a write to 0x20 holding 0x11111111, writing 0x22222222 -> valid=0 immediately, state=IDLE, and a subsequent read of 0x20 returns 0x11111111.
REQ-038 SHALL cover: DMEM_ERR_CHECK_EN with DEPTH=1024 and a read of 0x00001000 -> valid=1, addr_err=1, load_data=0; without the macro the same read returns the word at 0x0.
REQ-039 SHALL cover: LATENCY=1 with a read accepted at edge t -> valid high in cycle t+1 and the next acceptance no earlier than edge t+2.
